// File: rtl/rom_loader_pkg.sv
// Shared definitions for the Hack boot loader: FSM encoding, default sync marker, checksum width.
// ROM_LOADER_CHECKSUM_EN adds the CHECK state to the encoding.
package rom_loader_pkg;

  localparam logic [7:0]  DefaultSyncByte = 8'hA5;
  localparam int unsigned ChecksumW       = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenHi  = 3'd1,
    StLenLo  = 3'd2,
    StDataHi = 3'd3,
    StDataLo = 3'd4,
`ifdef ROM_LOADER_CHECKSUM_EN
    StCheck  = 3'd5,
`endif
    StDone   = 3'd6,
    StError  = 3'd7
  } state_t;

endpackage

// File: rtl/rom_loader_timeout.sv
// Idle watchdog: counts enabled cycles since the last clear and pulses o_Expired
// for one cycle when TIMEOUT_CYCLES is reached.
module rom_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Expired
);

  localparam int unsigned CountW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CountW-1:0] Limit = CountW'(TIMEOUT_CYCLES);

  logic [CountW-1:0] r_count;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_count <= '0;
    end else if (!i_Enable || i_Clear || (r_count == Limit)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CountW'(1);
    end
  end

  assign o_Expired = (r_count == Limit);

endmodule

// File: rtl/rom_loader.sv
// Boot sequencer: loads a framed byte stream into instruction ROM and holds the CPU in reset
// until a frame completes. Define ROM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned MAX_WORDS      = 32768,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = DefaultSyncByte
) (
  input  logic              i_CLK,
  input  logic              i_RESET_n,
  input  logic              i_Rx_Valid,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_CPU_RESET_n,
  output logic              o_ROM_Write,
  output logic [ADDR_W-1:0] o_ROM_Address,
  output logic [15:0]       o_ROM_Data,
  output logic              o_Busy,
  output logic              o_Error
);

  localparam logic [16:0] MaxLen = 17'(MAX_WORDS);
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t EndState = StCheck;
`else
  localparam state_t EndState = StDone;
`endif

  state_t            r_state, w_state_next;
  logic [7:0]        r_len_hi, r_data_hi;
  logic [15:0]       r_len, r_count, r_rom_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rom_write, r_hold, r_error;
  logic              w_busy, w_expired, w_timeout, w_take, w_start, w_last_word;
  logic [15:0]       w_len;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [ChecksumW-1:0] r_sum;
`endif

  assign w_len       = {r_len_hi, i_Rx_Byte};
  assign w_last_word = ((r_count + 16'd1) == r_len);
  assign w_timeout   = w_busy && w_expired;
  assign w_take      = i_Rx_Valid && !w_timeout;
  // DONE/ERROR accept a new sync so a back-to-back frame is not lost.
  assign w_start     = i_Rx_Valid && (i_Rx_Byte == SYNC_BYTE) &&
                       (r_state inside {StIdle, StDone, StError});

  rom_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_CLK    (i_CLK),
    .i_RESET_n(i_RESET_n),
    .i_Enable (w_busy),
    .i_Clear  (i_Rx_Valid),
    .o_Expired(w_expired)
  );

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone, StError: w_state_next = w_start ? StLenHi : StIdle;
      StLenHi:  if (w_take) w_state_next = StLenLo;
      StLenLo: begin
        if (w_take) begin
          if ({1'b0, w_len} > MaxLen) w_state_next = StError;
          else if (w_len == 16'd0)    w_state_next = EndState;
          else                        w_state_next = StDataHi;
        end
      end
      StDataHi: if (w_take) w_state_next = StDataLo;
      StDataLo: if (w_take) w_state_next = w_last_word ? EndState : StDataHi;
`ifdef ROM_LOADER_CHECKSUM_EN
      StCheck:  if (w_take) w_state_next = (i_Rx_Byte == r_sum) ? StDone : StError;
`endif
      default:  w_state_next = StIdle;
    endcase
    if (w_timeout) w_state_next = StError;
  end

  always_comb begin
    w_busy = !(r_state inside {StIdle, StDone, StError});
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_len_hi    <= '0;
      r_data_hi   <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_rom_data  <= '0;
      r_addr      <= '0;
      r_rom_write <= 1'b0;
      r_hold      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_rom_write <= 1'b0;
      if (w_start) begin
        r_addr  <= '0;
        r_count <= '0;
        r_hold  <= 1'b1;
      end else begin
        // Address advances the cycle after its write strobe.
        if (r_rom_write)        r_addr <= r_addr + ADDR_W'(1);
        if (r_state == StDone)  r_hold <= 1'b0;
        if (w_take && (r_state == StDataLo)) begin
          r_count     <= r_count + 16'd1;
          r_rom_write <= 1'b1;
          r_rom_data  <= {r_data_hi, i_Rx_Byte};
        end
      end
      if (w_take && (r_state == StLenHi))  r_len_hi  <= i_Rx_Byte;
      if (w_take && (r_state == StLenLo))  r_len     <= w_len;
      if (w_take && (r_state == StDataHi)) r_data_hi <= i_Rx_Byte;
      if (w_state_next == StError)     r_error <= 1'b1;
      else if (w_state_next == StDone) r_error <= 1'b0;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_take && (r_state inside {StLenHi, StLenLo, StDataHi, StDataLo})) begin
      r_sum <= r_sum + i_Rx_Byte;
    end
  end
`endif

  // ROM contents may be partial after an error, so the CPU stays held until a clean frame.
  assign o_CPU_RESET_n = i_RESET_n & ~r_hold;
  assign o_ROM_Write   = r_rom_write;
  assign o_ROM_Address = r_addr;
  assign o_ROM_Data    = r_rom_data;
  assign o_Busy        = w_busy;
  assign o_Error       = r_error;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized frames scored against
// a frame-level model. Honours ROM_LOADER_CHECKSUM_EN.
module tb_rom_loader;

  localparam int unsigned AddrW         = 15;
  localparam int unsigned MaxWords      = 32768;
  localparam int unsigned TimeoutCycles = 40;
  localparam logic [7:0]  Sync          = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             cpu_reset_n, rom_write, busy, error;
  logic [AddrW-1:0] rom_addr;
  logic [15:0]      rom_data;

  rom_loader #(
    .ADDR_W        (AddrW),
    .MAX_WORDS     (MaxWords),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .SYNC_BYTE     (Sync)
  ) dut (
    .i_CLK        (clk),
    .i_RESET_n    (rst_n),
    .i_Rx_Valid   (rx_valid),
    .i_Rx_Byte    (rx_byte),
    .o_CPU_RESET_n(cpu_reset_n),
    .o_ROM_Write  (rom_write),
    .o_ROM_Address(rom_addr),
    .o_ROM_Data   (rom_data),
    .o_Busy       (busy),
    .o_Error      (error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned      wcyc;
    logic [AddrW-1:0] addr;
    logic [15:0]      data;
  } wr_t;

  wr_t         wr_q[$];
  int unsigned sent_cyc[$];
  logic [15:0] frame_words[$];
  int          n_total = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (rom_write) wr_q.push_back('{wcyc: cyc, addr: rom_addr, data: rom_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    sent_cyc.push_back(cyc);
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends a frame built from frame_words; trunc<0 sends it whole, otherwise only trunc bytes.
  task automatic run_frame(input string tag, input int unsigned len_field, input int trunc,
                           input logic [7:0] sum_delta, input int gap_max);
    logic [7:0]  bytes[$];
    logic [15:0] lf;
    logic [7:0]  sum;
    int          n_send, n_words_exp, waited, n_cmp;
    bit          ok, sum_ok;
    lf = 16'(len_field);
    bytes.push_back(Sync);
    bytes.push_back(lf[15:8]);
    bytes.push_back(lf[7:0]);
    sum = lf[15:8] + lf[7:0];
    if (len_field <= MaxWords) begin
      for (int i = 0; i < int'(len_field); i++) begin
        bytes.push_back(frame_words[i][15:8]);
        bytes.push_back(frame_words[i][7:0]);
        sum = sum + frame_words[i][15:8] + frame_words[i][7:0];
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      bytes.push_back(sum + sum_delta);
`endif
    end
    sum_ok = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_ok = (sum_delta == 8'h00);
`endif
    n_send = (trunc < 0) ? bytes.size() : trunc;
    if (len_field > MaxWords) begin
      ok = 1'b0;
      n_words_exp = 0;
    end else begin
      n_words_exp = (n_send >= 3) ? (n_send - 3) / 2 : 0;
      if (n_words_exp > int'(len_field)) n_words_exp = int'(len_field);
      ok = (n_send == bytes.size()) && sum_ok;
    end

    wr_q.delete();
    sent_cyc.delete();
    for (int i = 0; i < n_send; i++) begin
      send_byte(bytes[i], (i == n_send - 1) ? 0 : int'($urandom_range(gap_max, 0)));
      if (i == 0) begin
        check({tag, "_cpu_held"}, cpu_reset_n, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
      end
    end
    waited = 0;
    while (busy && waited < int'(TimeoutCycles) + 20) begin
      tick();
      waited++;
    end
    check({tag, "_busy_drop"}, busy, 1'b0);
    check({tag, "_cpu_end_cycle"}, cpu_reset_n, 1'b0);
    check({tag, "_error"}, error, !ok);
    tick();
    check({tag, "_cpu_after"}, cpu_reset_n, ok);
    check({tag, "_error_hold"}, error, !ok);
    tick();
    check({tag, "_nwrites"}, wr_q.size(), n_words_exp);
    n_cmp = (wr_q.size() < n_words_exp) ? wr_q.size() : n_words_exp;
    for (int i = 0; i < n_cmp; i++) begin
      check({tag, "_waddr"}, wr_q[i].addr, i);
      check({tag, "_wdata"}, wr_q[i].data, frame_words[i]);
      check({tag, "_wcycle"}, wr_q[i].wcyc, sent_cyc[4 + 2 * i] + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned len;
    int          trunc;
    logic [7:0]  delta, g;

    #1;
    check("rst_cpu", cpu_reset_n, 1'b0);
    check("rst_write", rom_write, 1'b0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", rom_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_cpu", cpu_reset_n, 1'b1);

    frame_words = '{16'h1234, 16'hABCD};
    run_frame("normal", 2, -1, 8'h00, 2);

    wr_q.delete();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 2);
    check("garbage_writes", wr_q.size(), 0);
    check("garbage_busy", busy, 1'b0);
    check("garbage_cpu", cpu_reset_n, 1'b1);

    frame_words.delete();
    run_frame("oversize", 32'h8001, -1, 8'h00, 1);
    frame_words = '{16'h0BAD, 16'hF00D, 16'hA5A5};
    run_frame("recover", 3, -1, 8'h00, 0);

    frame_words.delete();
    run_frame("len0", 0, -1, 8'h00, 1);

    frame_words = '{16'h1200};
    run_frame("timeout", 1, 4, 8'h00, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
    frame_words = '{16'h0005};
    run_frame("csum_ok", 1, -1, 8'h00, 1);
    run_frame("csum_bad", 1, -1, 8'h01, 1);
`endif

    wr_q.delete();
    send_byte(Sync, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu", cpu_reset_n, 1'b0);
    check("midrst_write", rom_write, 1'b0);
    check("midrst_addr", rom_addr, 0);
    check("midrst_data", rom_data, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_error", error, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_idle_cpu", cpu_reset_n, 1'b1);
    frame_words = '{16'hBEEF, 16'h0102};
    run_frame("after_rst", 2, -1, 8'h00, 1);

    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(2, 0)) begin
        g = 8'($urandom_range(255, 0));
        if (g == Sync) g = 8'h00;
        send_byte(g, int'($urandom_range(1, 0)));
      end
      len = $urandom_range(5, 0);
      frame_words.delete();
      for (int w = 0; w < int'(len); w++) begin
        if ($urandom_range(3, 0) == 0) frame_words.push_back({Sync, 8'($urandom_range(255, 0))});
        else                           frame_words.push_back(16'($urandom_range(65535, 0)));
      end
      delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      trunc = -1;
      if (len > 0 && $urandom_range(5, 0) == 0) trunc = int'($urandom_range(2 + 2 * len, 3));
      run_frame("rand", len, trunc, delta, 3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot sequencer for the Hack CPU.
- Receives a program image as a byte stream from the UART receiver and writes it word-by-word into instruction ROM starting at address 0.
- Holds the CPU in reset while loading; releases it on success.
- Sits between the UART RX and the CPU/ROM write port in the top level; drives the CPU reset input.

Parameters:
- ADDR_W, 15, ROM word-address width.
- MAX_WORDS, 32768, largest accepted image length in words.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_CLK  in  1  system clock.
- i_RESET_n  in  1  asynchronous active-low reset.
- i_Rx_Valid  in  1  one-cycle strobe: i_Rx_Byte valid.
- i_Rx_Byte  in  8  received byte.
- o_CPU_RESET_n  out  1  active-low reset to CPU/PC.
- o_ROM_Write  out  1  one-cycle ROM write strobe.
- o_ROM_Address  out  ADDR_W  ROM write address.
- o_ROM_Data  out  16  ROM write data.
- o_Busy  out  1  frame in progress.
- o_Error  out  1  sticky: last frame failed.

Behaviour:
- Clock and reset: single clock i_CLK; reset is asynchronous, active-low, on i_RESET_n.
- Reset values:
  - state IDLE; o_CPU_RESET_n=0 while i_RESET_n low, 1 in IDLE after reset.
  - o_ROM_Write=0, o_ROM_Address=0, o_ROM_Data=0, o_Busy=0, o_Error=0.
  - word counter, timeout counter and checksum all 0.
- Frame format (all multi-byte fields big-endian): SYNC_BYTE, LEN_HI, LEN_LO, then LEN words as HI/LO byte pairs, then [checksum byte, see Optional Feature].
- States and transitions:
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> LEN_HI; set o_Busy=1 and o_CPU_RESET_n=0; clear address, counter and checksum. o_Error stays unchanged.
  - LEN_HI -> LEN_LO on byte.
  - LEN_LO on byte:
    - LEN > MAX_WORDS -> ERROR.
    - LEN == 0 -> CHECK or DONE (feature dependent).
    - else -> DATA_HI.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO: the cycle after the byte strobe, o_ROM_Data={hi,lo} and o_ROM_Write=1 for exactly 1 cycle at the current address. The address increments after the write. Last word -> CHECK or DONE; else -> DATA_HI.
  - DONE (1 cycle): o_Busy=0, o_Error=0, o_CPU_RESET_n=1 from the next cycle -> IDLE.
  - ERROR (1 cycle): o_Busy=0, o_Error=1 -> IDLE. o_CPU_RESET_n stays 0 until a subsequent frame completes, because the ROM is partially overwritten.
- Timeout: in any state other than IDLE/DONE/ERROR, the counter resets on each i_Rx_Valid. Reaching TIMEOUT_CYCLES -> ERROR.
- SYNC_BYTE inside a frame is treated as data, not a restart.
- Address counter wraps modulo 2^ADDR_W; unreachable when MAX_WORDS <= 2^ADDR_W.
- i_Rx_Valid during the DATA_LO write cycle, DONE or ERROR is not dropped: byte capture is independent of the write strobe.
- Reset asserted mid-frame: immediate return to reset values. The partial image stays in ROM.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- With it defined:
  - After the last data word (or after LEN_LO when LEN==0), CHECK expects one byte equal to the 8-bit modulo-256 sum of LEN_HI, LEN_LO and all data bytes.
  - Match -> DONE; mismatch -> ERROR.
- Without it: there is no CHECK state and no checksum byte; the last word goes directly to DONE.

Decomposition:
- Shared package/header: state encodings, default SYNC_BYTE, the checksum width constant.
- One natural sub-module: rom_loader_timeout. It is a load-clear counter with an expiry pulse, parameterised by TIMEOUT_CYCLES, and is reusable by the UART RX.

Test Plan:
- Normal load: A5 00 02 12 34 AB CD -> writes 0x1234@0 and 0xABCD@1, one strobe each. CPU reset is low from the A5 byte until the cycle after DONE, then high; o_Error=0.
- Garbage in IDLE: 00 FF 5A -> no writes, o_Busy=0, o_CPU_RESET_n=1.
- Oversize: A5 80 01 with MAX_WORDS=32768 -> ERROR; o_Error=1, no writes, CPU held in reset. A subsequent valid frame clears o_Error and releases the CPU.
- Timeout: A5 00 01 12, then silence for TIMEOUT_CYCLES -> ERROR, no write issued.
- Checksum (with ROM_LOADER_CHECKSUM_EN): A5 00 01 00 05 06 -> DONE (sum 06). The same frame with final byte 07 -> ERROR, but word 0x0005@0 is still written.
- Reset mid-frame: assert i_RESET_n=0 after A5 00 02 12 -> all outputs at reset values. A new frame loads correctly from address 0.
